mtr_pwm_drv: RTL and testbench

- Downstream consumer of the PID stage: converts signed lft_spd/rght_spd (11-bit, two's complement) into complementary H-bridge PWM pairs for left and right motors.
- Shared 11-bit free-running period counter, 2048 clk per PWM period.
- Duty applied only at period boundaries (glitch-free); configurable non-overlap (dead-time) between the two legs of each bridge.

---
 rtl/mtr_drv_pkg.sv | 16 +
 rtl/pwm11_pair.sv | 55 +++++
 rtl/mtr_pwm_drv.sv | 76 +++++++
 tb/tb_mtr_pwm_drv.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor PWM driver.
// Speed is 11-bit two's complement and duty is 11-bit unsigned.
package mtr_drv_pkg;

    typedef logic signed [10:0] spd_t;
    typedef logic [10:0]        duty_t;

    localparam duty_t DUTY_ZERO  = 11'h400;
    localparam int    PWM_PERIOD = 2048;

    // Adding 0x400 modulo 2^11 is the same as flipping the sign bit.
    function automatic duty_t spd_to_duty(input spd_t spd);
        return {~spd[10], spd[9:0]};
    endfunction

endpackage

// File: rtl/pwm11_pair.sv
// One H-bridge channel: a shadow duty register loaded once per period,
// forward/reverse compares with dead-time, and registered leg drives.
module pwm11_pair
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    input  duty_t cnt,
    input  logic  wrap,
    input  logic  en,
    input  duty_t duty_in,
    output logic  pwm1,
    output logic  pwm2
);

    localparam duty_t       NOV     = duty_t'(NONOVERLAP);
    localparam logic [11:0] NOV_EXT = 12'(NONOVERLAP);

    duty_t       duty_q;
    duty_t       duty_d;
    logic        pwm1_q;
    logic        pwm1_d;
    logic        pwm2_q;
    logic        pwm2_d;
    logic [11:0] rev_start;

    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            duty_d = en ? duty_in : DUTY_ZERO;
        end
        // A 12-bit start keeps the reverse leg off when its window would begin past the period end.
        rev_start = {1'b0, duty_q} + NOV_EXT;
        pwm1_d    = en && (cnt >= NOV) && (cnt < duty_q);
        pwm2_d    = en && ({1'b0, cnt} >= rev_start);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_ZERO;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm1_q <= pwm1_d;
            pwm2_q <= pwm2_d;
        end
    end

    assign pwm1 = pwm1_q;
    assign pwm2 = pwm2_q;

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual-motor complementary PWM driver with a shared period counter.
// It maps the signed PID speeds to duties and drives two pwm11_pair channels.
module mtr_pwm_drv
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = 32,
    parameter int CNT_W      = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
    output logic lftPWM1,
    output logic lftPWM2,
    output logic rghtPWM1,
    output logic rghtPWM2,
    output logic prd_strb
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;
    logic             prd_strb_q;
    logic             prd_strb_d;
    duty_t            lft_duty;
    duty_t            rght_duty;

    // The strobe is registered from the last count so it lines up with cnt==0.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        wrap       = (cnt_q == CNT_W'(PWM_PERIOD - 1));
        prd_strb_d = wrap;
        lft_duty   = spd_to_duty(lft_spd);
        rght_duty  = spd_to_duty(rght_spd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prd_strb_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prd_strb_q <= prd_strb_d;
        end
    end

    assign prd_strb = prd_strb_q;

    pwm11_pair #(
        .NONOVERLAP(NONOVERLAP)
    ) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt_q),
        .wrap   (wrap),
        .en     (en),
        .duty_in(lft_duty),
        .pwm1   (lftPWM1),
        .pwm2   (lftPWM2)
    );

    pwm11_pair #(
        .NONOVERLAP(NONOVERLAP)
    ) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt_q),
        .wrap   (wrap),
        .en     (en),
        .duty_in(rght_duty),
        .pwm1   (rghtPWM1),
        .pwm2   (rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Self-checking bench for mtr_pwm_drv: a period-level behavioural model checked every cycle,
// directed pulse-width scenarios with hand-computed counts, and randomized speed changes.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;

   localparam int NOV    = 32;
   localparam int PERIOD = 2048;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic signed [10:0] lft_spd = '0;
   logic signed [10:0] rght_spd = '0;
   logic              lftPWM1;
   logic              lftPWM2;
   logic              rghtPWM1;
   logic              rghtPWM2;
   logic              prd_strb;

   int tests = 0;
   int fails = 0;

   // Model state: cycles elapsed since reset, and the duty in force for each channel
   int m_t = 0;
   int m_duty [2];
   int low_run [2];
   bit prev1 [2];
   bit prev2 [2];
   int last_strb = 0;

   always #5 clk = ~clk;

   mtr_pwm_drv #(
      .NONOVERLAP(NOV),
      .CNT_W     (11)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .lft_spd (lft_spd),
      .rght_spd(rght_spd),
      .lftPWM1 (lftPWM1),
      .lftPWM2 (lftPWM2),
      .rghtPWM1(rghtPWM1),
      .rghtPWM2(rghtPWM2),
      .prd_strb(prd_strb)
   );

   // One comparison: count it and report a mismatch with both values
   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   // Drive the inputs; callers do this just after a falling edge
   task automatic applyStimulus(input bit enable, input int lft, input int rght);
      en       = enable;
      lft_spd  = 11'(lft);
      rght_spd = 11'(rght);
   endtask

   // Duty is the speed shifted up by half a period
   function automatic int speedToDuty(input int spd);
      return spd + 1024;
   endfunction

   // Forward leg is on for positions [NOV, duty), reverse leg from duty+NOV to the period end
   function automatic bit fwdOn(input int pos, input int duty);
      return (pos >= NOV) && (pos < duty);
   endfunction

   function automatic bit revOn(input int pos, input int duty);
      return pos >= duty + NOV;
   endfunction

   function automatic int randSpeed();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return -1024;
      if (r == 1) return 1023;
      if (r == 2) return 0;
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   // Model advance and compare: each falling edge follows exactly one rising edge,
   // so outputs now show the verdict for the position held before that edge.
   always @(negedge clk) begin
      int pos;
      bit e1 [2];
      bit e2 [2];
      bit a1 [2];
      bit a2 [2];
      bit eStrb;
      bit rise;
      a1[0] = lftPWM1;
      a2[0] = lftPWM2;
      a1[1] = rghtPWM1;
      a2[1] = rghtPWM2;
      if (!rst_n) begin
         m_t       = 0;
         last_strb = 0;
         for (int c = 0; c < 2; c++) begin
            m_duty[c]  = 1024;
            low_run[c] = 1000;
            prev1[c]   = 1'b0;
            prev2[c]   = 1'b0;
         end
         checkOutput("reset_outputs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strb}), 0);
      end else begin
         pos = m_t % PERIOD;
         for (int c = 0; c < 2; c++) begin
            e1[c] = en && fwdOn(pos, m_duty[c]);
            e2[c] = en && revOn(pos, m_duty[c]);
         end
         eStrb = (pos == PERIOD - 1);
         if (pos == PERIOD - 1) begin
            m_duty[0] = en ? speedToDuty(int'(lft_spd)) : 1024;
            m_duty[1] = en ? speedToDuty(int'(rght_spd)) : 1024;
         end
         m_t++;
         checkOutput("lftPWM1", int'(lftPWM1), int'(e1[0]));
         checkOutput("lftPWM2", int'(lftPWM2), int'(e2[0]));
         checkOutput("rghtPWM1", int'(rghtPWM1), int'(e1[1]));
         checkOutput("rghtPWM2", int'(rghtPWM2), int'(e2[1]));
         checkOutput("prd_strb", int'(prd_strb), int'(eStrb));
         // Bridge safety rules, checked on the DUT outputs directly
         for (int c = 0; c < 2; c++) begin
            checkOutput(c == 0 ? "lft_exclusive" : "rght_exclusive", int'(a1[c] && a2[c]), 0);
            rise = (a1[c] && !prev1[c]) || (a2[c] && !prev2[c]);
            if (rise) begin
               checkOutput(c == 0 ? "lft_deadtime" : "rght_deadtime",
                           (low_run[c] >= NOV) ? 1 : 0, 1);
            end
            if (a1[c] || a2[c]) low_run[c] = 0;
            else low_run[c]++;
            prev1[c] = a1[c];
            prev2[c] = a2[c];
         end
         if (prd_strb) begin
            checkOutput("strobe_interval", m_t - last_strb, PERIOD);
            last_strb = m_t;
         end
      end
   end

   // Wait for the strobe cycle, bounded by a little over one period
   task automatic waitStrobe();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < PERIOD + 4; i++) begin
         @(negedge clk);
         #1;
         if (prd_strb) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("strobe_timeout", 0, 1);
   endtask

   // Wait until the counter shows position p, bounded by a little over one period
   task automatic waitPos(input int p);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < PERIOD + 4; i++) begin
         @(negedge clk);
         #1;
         if ((m_t % PERIOD) == p) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("position_timeout", 0, 1);
   endtask

   // Count high cycles per output over the next full period, starting just after a strobe
   task automatic countPeriod(output int l1, output int l2, output int r1, output int r2);
      l1 = 0;
      l2 = 0;
      r1 = 0;
      r2 = 0;
      repeat (PERIOD) begin
         @(negedge clk);
         #1;
         l1 += int'(lftPWM1);
         l2 += int'(lftPWM2);
         r1 += int'(rghtPWM1);
         r2 += int'(rghtPWM2);
      end
   endtask

   task automatic checkCounts(input string tag, input int l1, input int l2, input int r1, input int r2,
                              input int x1, input int x2, input int y1, input int y2);
      checkOutput({tag, "_lft1"}, l1, x1);
      checkOutput({tag, "_lft2"}, l2, x2);
      checkOutput({tag, "_rght1"}, r1, y1);
      checkOutput({tag, "_rght2"}, r2, y2);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int l1, l2, r1, r2;
      int n;

      // Zero speed from reset: both legs 992 cycles per period
      applyStimulus(1'b1, 0, 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      waitStrobe();
      countPeriod(l1, l2, r1, r2);
      checkCounts("zero", l1, l2, r1, r2, 992, 992, 992, 992);

      // Full forward left, full reverse right; the current period still runs the old duty
      applyStimulus(1'b1, 1023, -1024);
      countPeriod(l1, l2, r1, r2);
      checkCounts("extreme_old", l1, l2, r1, r2, 992, 992, 992, 992);
      countPeriod(l1, l2, r1, r2);
      checkCounts("extreme", l1, l2, r1, r2, 2015, 0, 0, 2016);

      // Mid-period speed change only takes effect at the next boundary
      applyStimulus(1'b1, 0, 0);
      countPeriod(l1, l2, r1, r2);
      fork
         countPeriod(l1, l2, r1, r2);
         begin
            waitPos(500);
            applyStimulus(1'b1, 200, 0);
         end
      join
      checkCounts("midchange_cur", l1, l2, r1, r2, 992, 992, 992, 992);
      countPeriod(l1, l2, r1, r2);
      checkCounts("midchange_next", l1, l2, r1, r2, 1192, 792, 992, 992);

      // Enable dropped at 700 and raised at 1500; duty 1224 left, 1024 right still in force
      fork
         countPeriod(l1, l2, r1, r2);
         begin
            waitPos(700);
            applyStimulus(1'b0, 200, 0);
            waitPos(1500);
            applyStimulus(1'b1, -512, 0);
         end
      join
      checkCounts("en_gap", l1, l2, r1, r2, 668, 548, 668, 548);
      countPeriod(l1, l2, r1, r2);
      checkCounts("en_resume", l1, l2, r1, r2, 480, 1504, 992, 992);

      // Asynchronous reset while reverse legs are high
      waitPos(1700);
      checkOutput("pre_reset_lft2", int'(lftPWM2), 1);
      checkOutput("pre_reset_rght2", int'(rghtPWM2), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strb}), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= PERIOD + 4; i++) begin
         @(negedge clk);
         #1;
         if (prd_strb) begin
            n = i;
            break;
         end
      end
      checkOutput("first_strobe_after_reset", n, PERIOD);

      // Randomized speeds on both channels with enable held high
      for (int i = 0; i < 16 * PERIOD; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 399) == 0) lft_spd = 11'(randSpeed());
         if ($urandom_range(0, 399) == 0) rght_spd = 11'(randSpeed());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
